// File: rtl/edge_gen.sv
// Programmable pulse-train generator: on an accepted start, emits num pulses of high_len/low_len
// cycles on a registered output, then a one-cycle done strobe. Optional abort: EDGE_GEN_ABORT_EN.
module edge_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num,
`ifdef EDGE_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             busy,
  output logic             a,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, l_q, l_d, phase_q, phase_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             a_q, a_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic             abort_w;

`ifdef EDGE_GEN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Zero-length phases are stretched to one cycle so every pulse has real edges.
          h_d     = (high_len == '0) ? CNT_W'(1) : high_len;
          l_d     = (low_len == '0) ? CNT_W'(1) : low_len;
          rem_d   = num;
          phase_d = '0;
          state_d = (num != '0) ? StHigh : StDone;
        end
      end
      StHigh: begin
        if (abort_w) begin
          phase_d = '0;
          state_d = StDone;
        end else if (phase_q == h_q - CNT_W'(1)) begin
          phase_d = '0;
          state_d = StLow;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      StLow: begin
        if (abort_w) begin
          phase_d = '0;
          state_d = StDone;
        end else if (phase_q == l_q - CNT_W'(1)) begin
          phase_d = '0;
          rem_d   = rem_q - NUM_W'(1);
          state_d = (rem_q == NUM_W'(1)) ? StDone : StHigh;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    a_d     = (state_d == StHigh);
    busy_d  = (state_d == StHigh) || (state_d == StLow);
    done_d  = (state_d == StDone);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      l_q     <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign a     = a_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: directed vector table, corner sequences and a randomized run
// against a timing model derived from the pulse-train formulas.
module tb_edge_gen;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] high_len, low_len, num;
  logic       ready, busy, a, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  edge_gen #(.CNT_W(8), .NUM_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .high_len (high_len),
    .low_len  (low_len),
    .num      (num),
`ifdef EDGE_GEN_ABORT_EN
    .abort    (abort),
`endif
    .ready    (ready),
    .busy     (busy),
    .a        (a),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h;
    int l;
    int n;
    int done_off;
    int edges;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    start = 1'b0;
    while (ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", int'(ready), 1);
  endtask

  // Drives one start in cycle T and scrambles the inputs afterwards; returns T.
  task automatic drive_start(input int h, input int l, input int n, output int t);
    @(posedge clk); #1;
    start    = 1'b1;
    high_len = 8'(h);
    low_len  = 8'(l);
    num      = 8'(n);
    t        = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
    high_len = 8'($urandom);
    low_len  = 8'($urandom);
    num      = 8'($urandom);
  endtask

  vec_t vecs[$];
  int   t0, got, rises, falls, nacc, ndone;
  int   acc[$];
  logic pa;

  // Random-run model state
  bit   have_tr;
  int   mt, mh, ml, mn, off, per, p;
  bit   ea, eb, ed, er;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    high_len = '0; low_len = '0; num = '0;
    #1;
    check("reset_a", int'(a), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ready", int'(ready), 1);
    #21 rst = 1'b0;

    vecs = '{
      '{h: 3,   l: 2, n: 4,   done_off: 21,   edges: 4},
      '{h: 0,   l: 0, n: 3,   done_off: 7,    edges: 3},
      '{h: 7,   l: 3, n: 0,   done_off: 1,    edges: 0},
      '{h: 1,   l: 1, n: 1,   done_off: 3,    edges: 1},
      '{h: 2,   l: 3, n: 2,   done_off: 11,   edges: 2},
      '{h: 255, l: 0, n: 1,   done_off: 257,  edges: 1},
      '{h: 1,   l: 4, n: 255, done_off: 1276, edges: 255}
    };
    foreach (vecs[i]) begin
      wait_idle();
      drive_start(vecs[i].h, vecs[i].l, vecs[i].n, t0);
      got = -1; rises = 0; falls = 0; pa = 1'b0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (a && !pa) rises++;
        if (!a && pa) falls++;
        pa = a;
        if (done) begin
          got = cyc - t0;
          break;
        end
      end
      check($sformatf("vec%0d_done_time", i), got, vecs[i].done_off);
      check($sformatf("vec%0d_rises", i), rises, vecs[i].edges);
      check($sformatf("vec%0d_falls", i), falls, vecs[i].edges);
      check($sformatf("vec%0d_a_at_done", i), int'(a), 0);
      @(negedge clk);
      check($sformatf("vec%0d_ready_after", i), int'(ready), 1);
    end

    // start held high: H=L=1, N=1 trains every 4 cycles, no extra edges while busy.
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; high_len = 8'd1; low_len = 8'd1; num = 8'd1;
    t0 = cyc; rises = 0; pa = 1'b0; acc.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready && start) acc.push_back(cyc - t0);
      if (a && !pa) rises++;
      pa = a;
      @(posedge clk); #1;
    end
    start = 1'b0;
    nacc = acc.size();
    check("held_accepts", nacc, 3);
    if (nacc == 3) begin
      check("held_accept1", acc[1], 4);
      check("held_accept2", acc[2], 8);
    end
    check("held_rises", rises, 3);

`ifdef EDGE_GEN_ABORT_EN
    wait_idle();
    drive_start(5, 1, 2, t0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_a", int'(a), 0);
    check("abort_done", int'(done), 1);
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
`endif

    // Reset mid-train: outputs clear asynchronously and no done follows.
    wait_idle();
    drive_start(10, 10, 5, t0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_a", int'(a), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_ready", int'(ready), 1);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (120) begin
      @(negedge clk);
      if (done || !ready) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // Randomized run against the timing model.
    wait_idle();
    have_tr = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 3) == 0);
      high_len = 8'($urandom_range(0, 4));
      low_len  = 8'($urandom_range(0, 4));
      num      = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      @(negedge clk);
      ea = 1'b0; eb = 1'b0; ed = 1'b0; er = 1'b1;
      if (have_tr) begin
        off = cyc - mt;
        per = mh + ml;
        p   = mn * per;
        if (off >= 1 && off <= p) begin
          eb = 1'b1; er = 1'b0;
          ea = ((off - 1) % per) < mh;
        end else if (off == p + 1) begin
          ed = 1'b1; er = 1'b0;
        end
      end
      check("rnd_a", int'(a), int'(ea));
      check("rnd_busy", int'(busy), int'(eb));
      check("rnd_done", int'(done), int'(ed));
      check("rnd_ready", int'(ready), int'(er));
      if (er && start) begin
        have_tr = 1'b1;
        mt = cyc;
        mh = (high_len == 0) ? 1 : int'(high_len);
        ml = (low_len == 0) ? 1 : int'(low_len);
        mn = int'(num);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
